// File: rtl/pca_pkg.sv
// pca_pkg: shared Q1.7 sample type, FSM states and fixed-point limits for the Givens rotator.
package pca_pkg;
  localparam int FRAC_BITS = 7;
  localparam int SAT_MAX = 127;
  localparam int SAT_MIN = -128;
  typedef logic signed [7:0] q17_t;
  typedef enum logic [1:0] {IDLE, ROTATE, DRAIN, DONE} state_t;
endpackage

// File: rtl/givens_rotator_if.sv
// givens_rotator_if: coefficient load, element-pair input and result output handshakes.
interface givens_rotator_if;
  import pca_pkg::*;
  logic sincos_valid;
  q17_t cosine_data;
  q17_t sine_data;
  logic row_valid;
  logic row_ready;
  q17_t x_p;
  q17_t x_q;
  logic out_valid;
  logic out_ready;
  q17_t y_p;
  q17_t y_q;
  logic busy;
  logic done;
  modport master (
    output sincos_valid, cosine_data, sine_data, row_valid, x_p, x_q, out_ready,
    input row_ready, out_valid, y_p, y_q, busy, done
  );
  modport slave (
    input sincos_valid, cosine_data, sine_data, row_valid, x_p, x_q, out_ready,
    output row_ready, out_valid, y_p, y_q, busy, done
  );
endinterface

// File: rtl/givens_mac.sv
// givens_mac: one rotation lane, a*xa +/- b*xb, shifted by FRAC_BITS and saturated, two pipeline stages.
// Define GIVENS_ROUND_EN for round-half-up; otherwise the shift truncates toward minus infinity.
module givens_mac
  import pca_pkg::*;
#(
  parameter bit SUB = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  q17_t a,
  input  q17_t xa,
  input  q17_t b,
  input  q17_t xb,
  output q17_t y
);
  logic signed [15:0] pa, pb;
  logic signed [16:0] sum, adj;
  logic signed [9:0] sh;
  q17_t sat;
  // subtracting the product avoids ever negating s, so s = -128 stays exact
  assign sum = SUB ? 17'(pa) - 17'(pb) : 17'(pa) + 17'(pb);
`ifdef GIVENS_ROUND_EN
  assign adj = sum + 17'sd64;
`else
  assign adj = sum;
`endif
  assign sh = 10'(adj >>> FRAC_BITS);
  assign sat = sh > 10'(SAT_MAX) ? 8'(SAT_MAX) : sh < 10'(SAT_MIN) ? 8'(SAT_MIN) : sh[7:0];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pa <= '0;
      pb <= '0;
      y  <= '0;
    end else if (en) begin
      pa <= 16'(a) * 16'(xa);
      pb <= 16'(b) * 16'(xb);
      y  <= sat;
    end
endmodule

// File: rtl/givens_rotator.sv
// givens_rotator: applies a latched Givens rotation (c, s) to N_COLS element pairs with a 2-stage stallable pipeline.
module givens_rotator
  import pca_pkg::*;
#(
  parameter int N_COLS = 4
) (
  input logic clk,
  input logic rst_n,
  givens_rotator_if.slave bus
);
  state_t state, nxt;
  q17_t c, s;
  logic [8:0] cnt, ocnt;
  logic v1, stall, en, acc, hs;
  assign stall = bus.out_valid & ~bus.out_ready;
  assign en = ~stall;
  assign bus.row_ready = state == ROTATE && cnt < 9'(N_COLS) && !stall;
  assign acc = bus.row_valid & bus.row_ready;
  assign hs = bus.out_valid & bus.out_ready;
  assign bus.busy = state != IDLE;
  assign bus.done = state == DONE;
  always_comb
    nxt = state == IDLE   ? (bus.sincos_valid ? ROTATE : IDLE) :
          state == ROTATE ? (acc && cnt == 9'(N_COLS - 1) ? DRAIN : ROTATE) :
          state == DRAIN  ? (hs && ocnt == 9'(N_COLS - 1) ? DONE : DRAIN) : IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state         <= IDLE;
      c             <= '0;
      s             <= '0;
      cnt           <= '0;
      ocnt          <= '0;
      v1            <= 1'b0;
      bus.out_valid <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE && bus.sincos_valid) begin
        c    <= bus.cosine_data;
        s    <= bus.sine_data;
        cnt  <= '0;
        ocnt <= '0;
      end else begin
        if (acc) cnt <= cnt + 9'd1;
        if (hs) ocnt <= ocnt + 9'd1;
      end
      if (en) begin
        v1            <= acc;
        bus.out_valid <= v1;
      end
    end
  givens_mac #(.SUB(1'b0)) mac_p (
    .clk(clk), .rst_n(rst_n), .en(en),
    .a(c), .xa(bus.x_p), .b(s), .xb(bus.x_q), .y(bus.y_p)
  );
  givens_mac #(.SUB(1'b1)) mac_q (
    .clk(clk), .rst_n(rst_n), .en(en),
    .a(c), .xa(bus.x_q), .b(s), .xb(bus.x_p), .y(bus.y_q)
  );
endmodule

// File: tb/tb_givens_rotator.sv
// tb_givens_rotator: directed rotations with a scoreboard queue checked by an independent output monitor.
module tb_givens_rotator;
  import pca_pkg::*;
  typedef struct {
    int yp;
    int yq;
    int lat;
  } exp_t;
`ifdef GIVENS_ROUND_EN
  localparam int B0 = 20;
`else
  localparam int B0 = 19;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  givens_rotator_if bus ();
  givens_rotator #(.N_COLS(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  exp_t sb[$];
  int total = 0, passed = 0, cyc = 0, done_cnt = 0, stall_cycles = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask
  initial begin : monitor
    logic stall_prev;
    int yp_prev, yq_prev;
    exp_t e;
    stall_prev = 1'b0;
    yp_prev = 0;
    yq_prev = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) stall_prev = 1'b0;
      else begin
        if (bus.done) done_cnt++;
        if (stall_prev) begin
          chk("stall_hold_y_p", bus.y_p, yp_prev);
          chk("stall_hold_y_q", bus.y_q, yq_prev);
        end
        if (bus.out_valid && !bus.out_ready) begin
          chk("stall_row_ready", bus.row_ready, 0);
          stall_cycles++;
        end
        if (bus.out_valid && bus.out_ready) begin
          if (sb.size() == 0) chk("unexpected_output", 1, 0);
          else begin
            e = sb.pop_front();
            chk("y_p", bus.y_p, e.yp);
            chk("y_q", bus.y_q, e.yq);
            if (e.lat >= 0) chk("latency", cyc - e.lat, 2);
          end
        end
        stall_prev = bus.out_valid && !bus.out_ready;
        yp_prev = bus.y_p;
        yq_prev = bus.y_q;
      end
    end
  end
  task automatic start(input int c, input int s);
    bus.cosine_data = 8'(c);
    bus.sine_data = 8'(s);
    bus.sincos_valid = 1'b1;
    @(posedge clk);
    #1 bus.sincos_valid = 1'b0;
  endtask
  task automatic send(input int xp, input int xq, input int ep, input int eq, input bit lat);
    int n;
    exp_t e;
    bus.x_p = 8'(xp);
    bus.x_q = 8'(xq);
    bus.row_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.row_ready) break;
      if (++n > 50) break;
    end
    if (n > 50) chk("accept_timeout", 0, 1);
    else begin
      e.yp = ep;
      e.yq = eq;
      e.lat = lat ? cyc : -1;
      sb.push_back(e);
    end
    @(posedge clk);
    #1 bus.row_valid = 1'b0;
  endtask
  task automatic wait_done(input int d0);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("done_pulses", done_cnt - d0, 1);
    chk("scoreboard_empty", sb.size(), 0);
    chk("busy_after_done", bus.busy, 0);
    @(posedge clk);
    #1;
  endtask
  task automatic zero_chk();
    chk("rst_row_ready", bus.row_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_y_p", bus.y_p, 0);
    chk("rst_y_q", bus.y_q, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int d0, s0;
    bus.sincos_valid = 1'b0;
    bus.cosine_data = '0;
    bus.sine_data = '0;
    bus.row_valid = 1'b0;
    bus.x_p = '0;
    bus.x_q = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 zero_chk();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    d0 = done_cnt;
    start(127, 0);
    send(100, -50, 99, -50, 1'b1);
    send(0, 0, 0, 0, 1'b0);
    send(-128, 127, -127, 126, 1'b0);
    send(0, 127, 0, 126, 1'b0);
    wait_done(d0);
    d0 = done_cnt;
    start(0, 127);
    send(10, 20, B0, -10, 1'b1);
    send(0, 0, 0, 0, 1'b0);
    send(1, 0, 0, -1, 1'b0);
    send(-128, 127, 126, 127, 1'b0);
    wait_done(d0);
    d0 = done_cnt;
    start(127, 127);
    send(127, 127, 127, 0, 1'b1);
    send(-128, -128, -128, 0, 1'b0);
    send(127, -128, -1, -128, 1'b0);
    send(0, 0, 0, 0, 1'b0);
    wait_done(d0);
    d0 = done_cnt;
    s0 = stall_cycles;
    start(64, 64);
    send(10, 20, 15, 5, 1'b0);
    send(-30, 10, -10, 20, 1'b0);
    bus.out_ready = 1'b0;
    fork
      begin
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join_none
    send(40, 40, 40, 0, 1'b0);
    send(-100, -20, -60, 40, 1'b0);
    wait_done(d0);
    chk("stall_cycles", stall_cycles - s0, 3);
    d0 = done_cnt;
    start(64, 64);
    send(2, 4, 3, 1, 1'b0);
    chk("busy_in_rotate", bus.busy, 1);
    bus.cosine_data = 8'sd127;
    bus.sine_data = 8'sd0;
    bus.sincos_valid = 1'b1;
    send(-8, 8, 0, 8, 1'b0);
    bus.sincos_valid = 1'b0;
    send(100, 0, 50, -50, 1'b0);
    send(0, -6, -3, -3, 1'b0);
    wait_done(d0);
    d0 = done_cnt;
    start(127, 0);
    send(100, -50, 99, -50, 1'b0);
    send(0, 0, 0, 0, 1'b0);
    rst_n = 1'b0;
    #1 zero_chk();
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("no_done_after_reset", done_cnt - d0, 0);
    chk("idle_after_reset", bus.busy, 0);
    @(posedge clk);
    #1;
    d0 = done_cnt;
    start(0, 127);
    send(10, 20, B0, -10, 1'b1);
    send(0, 0, 0, 0, 1'b0);
    send(1, 0, 0, -1, 1'b0);
    send(-128, 127, 126, 127, 1'b0);
    wait_done(d0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/givens_rotator.md
GIVENS_ROTATOR -- requirements
Module: givens_rotator

Interface
REQ-001 The module SHALL have one parameter: N_COLS, default 4, the number of element pairs per rotation (range 1..255).
REQ-002 The module SHALL have the following ports, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- sincos_valid  in  1  one-cycle strobe; cosine_data/sine_data valid.
- cosine_data  in  8  signed Q1.7 cos(theta).
- sine_data  in  8  signed Q1.7 sin(theta).
- row_valid  in  1  element pair x_p/x_q valid.
- row_ready  out  1  block accepts an element pair.
- x_p  in  8  signed row-p element.
- x_q  in  8  signed row-q element.
- out_valid  out  1  y_p/y_q valid.
- out_ready  in  1  downstream accepts the result.
- y_p  out  8  signed rotated row-p element.
- y_q  out  8  signed rotated row-q element.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the last result handshake.

Function
REQ-003 The FSM SHALL have four states: IDLE, ROTATE, DRAIN, DONE.
REQ-004 In IDLE with sincos_valid=1, the block SHALL latch c and s, clear the column counter, and enter ROTATE on the next cycle.
REQ-005 The block SHALL ignore sincos_valid in every state other than IDLE; the latched c and s SHALL stay unchanged.
REQ-006 row_ready SHALL be 1 only in ROTATE, while the counter is below N_COLS and the pipeline is not stalled.
REQ-007 An element pair SHALL be accepted, and the counter incremented, only on a cycle where row_valid and row_ready are both 1.
REQ-008 After the N_COLS-th accept, the FSM SHALL enter DRAIN.
REQ-009 When the N_COLS-th result handshakes (out_valid and out_ready both 1), the FSM SHALL go DRAIN->DONE, assert done for exactly one cycle in DONE, then return to IDLE.
REQ-010 Arithmetic SHALL be: y_p = c*x_p + s*x_q and y_q = c*x_q - s*x_p.
- Each product is 16-bit signed; each sum is 17-bit signed.
- Negation of s is never formed, so s=-128 is exact.
REQ-011 Each 17-bit sum SHALL be scaled by an arithmetic shift right of 7, rounded per REQ-018, then saturated to [-128, 127].
REQ-012 The datapath SHALL be two stages: stage 1 registers the four products; stage 2 registers the sum, round and saturate results into y_p/y_q and out_valid.
REQ-013 Latency from accept to out_valid SHALL be 2 cycles when there is no stall.
REQ-014 When out_valid=1 and out_ready=0, both pipeline stages SHALL hold, row_ready SHALL be 0, and y_p/y_q SHALL stay stable.
REQ-015 With continuous row_valid and out_ready, throughput SHALL be one pair per cycle; a full rotation takes N_COLS+3 cycles from ROTATE entry to the done pulse.
REQ-016 An accept and an output handshake on the same cycle SHALL both take effect.

Reset
REQ-017 On rst_n=0, asynchronously:
- FSM goes to IDLE; counter, latched c/s and pipeline valids clear.
- row_ready, out_valid, busy, done, y_p and y_q are 0.
- Any in-flight rotation is abandoned with no done pulse.
- Operation resumes on the first clock after rst_n rises.

Configuration
REQ-018 Macro GIVENS_ROUND_EN SHALL select the rounding mode.
- Defined: add 64 to the 17-bit sum before the shift (round half up).
- Undefined: plain arithmetic shift (truncate toward minus infinity).
- Saturation applies in both modes.

Structure
REQ-019 A shared package (pca_pkg) SHALL hold:
- typedef for the Q1.7 sample type;
- the FSM state enum;
- constant FRAC_BITS=7;
- constants SAT_MAX=127 and SAT_MIN=-128.
REQ-020 One sub-module, givens_mac, SHALL implement one output lane (multiply pair, add, round, saturate); it SHALL be instantiated twice.

Verification
REQ-021 The bench SHALL cover these directed cases with GIVENS_ROUND_EN defined; the truncating build is tested separately and matches except where rounding differs.
- c=127, s=0, pair (100,-50) -> (99,-50), out_valid 2 cycles after accept.
- c=0, s=127, pair (10,20) -> (20,-10).
- c=127, s=127, pair (127,127) -> (127,0) (positive saturation); pair (-128,-128) -> (-128,0).
- N_COLS=4 with out_ready held low for 3 cycles mid-stream -> y_p/y_q stable, row_ready=0, all 4 results in order, done pulses once.
- sincos_valid during ROTATE with new c/s -> results still use the original c/s.
- rst_n low after 2 of 4 accepts -> all outputs 0 at once, no done; a fresh sincos_valid restarts correctly.
